// File: rtl/fpred_pipe.sv
// Two-stage floating-point predicate/compare unit with valid/ready flow control.
// Operands are compared as sign-magnitude values; NaN/inf receive no special treatment.
module fpred_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    // Final predicate selection from the S1 partial results.
    function automatic logic eval_pred(
        input logic [2:0] op,
        input logic       zx,
        input logic       zmx,
        input logic       zxy,
        input logic       eq,
        input logic       sx,
        input logic       sy,
        input logic       mlt
    );
        logic feq;
        logic flt;
        logic res;
        feq = eq | zxy;
        flt = ~feq & ((sx & ~sy) | (~sx & ~sy & mlt) | (sx & sy & ~mlt));
        case (op)
            3'd0:    res = zx;
            3'd1:    res = ~sx & ~zx;
            3'd2:    res = sx & ~zmx;
            3'd3:    res = feq;
            3'd4:    res = flt;
            3'd5:    res = flt | feq;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic             vld_p1;
    logic [2:0]       op_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             zx_p1;
    logic             zmx_p1;
    logic             zxy_p1;
    logic             eq_p1;
    logic             sx_p1;
    logic             sy_p1;
    logic             mlt_p1;

    logic             vld_p2;
    logic             adv_p1;
    logic             adv_p2;

    // A stage may load whenever it is empty or its current content moves on.
    assign adv_p2   = ~vld_p2 | out_ready;
    assign adv_p1   = ~vld_p1 | adv_p2;
    assign in_ready = adv_p1;

    // ---- Stage S1: operand decode into partial results ----
    always_ff @(posedge clk) begin
        if (rstn) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            op_p1  <= in_op;
            tag_p1 <= in_tag;
            zx_p1  <= (in_x == 32'h0);
            zmx_p1 <= (in_x[30:0] == 31'h0);
            zxy_p1 <= (in_x[30:0] == 31'h0) && (in_y[30:0] == 31'h0);
            eq_p1  <= (in_x == in_y);
            sx_p1  <= in_x[31];
            sy_p1  <= in_y[31];
            mlt_p1 <= (in_x[30:0] < in_y[30:0]);
        end
    end

    // ---- Stage S2: final result, drives the outputs directly ----
    always_ff @(posedge clk) begin
        if (rstn) begin
            vld_p2      <= 1'b0;
            out_res     <= 1'b0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_res     <= eval_pred(op_p1, zx_p1, zmx_p1, zxy_p1, eq_p1,
                                         sx_p1, sy_p1, mlt_p1);
                out_tag     <= tag_p1;
                out_illegal <= op_p1[2] & op_p1[1];
            end
        end
    end

    assign out_valid = vld_p2;

endmodule

// File: tb/tb_fpred_pipe.sv
// Directed bench for fpred_pipe: a value-level reference model with a result queue,
// plus literal expectations for the listed predicate and compare vectors.
module tb_fpred_pipe;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_x;
    logic [31:0]      in_y;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_res;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    int checks   = 0;
    int failures = 0;
    int lit_cur  = -1;

    typedef struct {
        logic             res;
        logic             ill;
        logic [TAG_W-1:0] tag;
        int               lit;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    fpred_pipe #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Operands interpreted as signed integers in sign-magnitude form.
    function automatic logic model_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint vx;
        longint vy;
        vx = longint'({1'b0, x[30:0]});
        vy = longint'({1'b0, y[30:0]});
        if (x[31]) vx = -vx;
        if (y[31]) vy = -vy;
        case (op)
            3'd0:    return x == 32'h0;
            3'd1:    return vx > 0;
            3'd2:    return vx < 0;
            3'd3:    return vx == vy;
            3'd4:    return vx < vy;
            3'd5:    return vx <= vy;
            default: return 1'b0;
        endcase
    endfunction

    logic             prev_stall = 1'b0;
    logic             prev_res;
    logic             prev_ill;
    logic [TAG_W-1:0] prev_tag;

    // Compare process: scores every transfer and holds outputs steady while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_res", out_res, prev_res);
                check("stall_tag", out_tag, prev_tag);
                check("stall_ill", out_illegal, prev_ill);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("res", out_res, e.res);
                    check("illegal", out_illegal, e.ill);
                    check("tag", out_tag, e.tag);
                    if (e.lit >= 0) check("res_literal", out_res, e.lit[0]);
                end
            end
            if (in_valid && in_ready) begin
                e.res = model_res(in_op, in_x, in_y);
                e.ill = (in_op >= 3'd6);
                e.tag = in_tag;
                e.lit = lit_cur;
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_res;
            prev_ill   = out_illegal;
            prev_tag   = out_tag;
        end
    end

    // Entered just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [TAG_W-1:0] tag, input int lit);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_x     = x;
        in_y     = y;
        in_tag   = tag;
        lit_cur  = lit;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lit_cur  = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] pv_x [4];
    int          pv_lit [3][4];

    initial begin
        pv_x   = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000};
        pv_lit = '{'{1, 0, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
        rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_x = '0; in_y = '0; in_tag = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single predicates with latency check.
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < 4; i++) begin
                send(3'(op), pv_x[i], 32'h1234_5678, 5'(op * 4 + i), pv_lit[op][i]);
                @(negedge clk);
                check("lat_cycle1", out_valid, 0);
                @(negedge clk);
                check("lat_cycle2", out_valid, 1);
                @(posedge clk);
                #1;
            end
        end

        // Compares, back to back.
        send(3'd3, 32'h0000_0000, 32'h8000_0000, 5'd20, 1);
        send(3'd4, 32'hBF80_0000, 32'h3F80_0000, 5'd21, 1);
        send(3'd4, 32'hC000_0000, 32'hBF80_0000, 5'd22, 1);
        send(3'd5, 32'h3F80_0000, 32'h3F80_0000, 5'd23, 1);
        send(3'd4, 32'h3F80_0000, 32'h3F80_0000, 5'd24, 0);
        send(3'd4, 32'h8000_0000, 32'h0000_0000, 5'd25, 0);
        send(3'd4, 32'h0000_0000, 32'hBF80_0000, 5'd26, 0);
        send(3'd5, 32'hC000_0000, 32'hC000_0000, 5'd27, 1);
        idle(4);

        // Backpressure: two beats fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        send(3'd1, 32'h3F80_0000, 32'h0, 5'd1, 1);
        send(3'd2, 32'h3F80_0000, 32'h0, 5'd2, 0);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_tag", out_tag, 1);
        @(posedge clk);
        #1;
        fork
            begin
                send(3'd3, 32'h4000_0000, 32'h4000_0000, 5'd3, 1);
                send(3'd4, 32'h4000_0000, 32'h3F80_0000, 5'd4, 0);
                send(3'd0, 32'h8000_0000, 32'h0, 5'd5, 0);
            end
            begin
                idle(2);
                out_ready = 1'b1;
            end
        join
        idle(4);
        check("bp_drained", q.size(), 0);

        // Full throughput.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(3'(i % 6), 32'h3F80_0000 + 32'(i), 32'h3F80_0003, 5'(8 + i), -1);
            end
            begin
                for (int c = 0; c <= 10; c++) begin
                    @(negedge clk);
                    if (c < 8) check("tp_in_ready", in_ready, 1);
                    check("tp_out_valid", out_valid, (c >= 2 && c <= 9) ? 1 : 0);
                end
            end
        join
        @(posedge clk);
        #1;

        // Reserved op.
        send(3'd6, 32'h3F80_0000, 32'h0, 5'd9, 0);
        @(negedge clk);
        @(negedge clk);
        check("rsv_valid", out_valid, 1);
        check("rsv_res", out_res, 0);
        check("rsv_illegal", out_illegal, 1);
        check("rsv_tag", out_tag, 9);
        @(posedge clk);
        #1;
        send(3'd7, 32'h0, 32'h0, 5'd10, 0);
        idle(3);

        // Reset with both stages full and a competing input beat.
        out_ready = 1'b0;
        send(3'd1, 32'h3F80_0000, 32'h0, 5'd17, 1);
        send(3'd0, 32'h0000_0000, 32'h0, 5'd18, 1);
        rstn     = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_x     = 32'h0;
        in_tag   = 5'd19;
        @(posedge clk);
        #1;
        rstn     = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_res", out_res, 0);
        check("mid_rst_out_tag", out_tag, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(3'd2, 32'hBF80_0000, 32'h0, 5'd30, 1);
        idle(4);
        check("final_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
